// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// One transaction in flight; data wins unless fetch has waited STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state  | meaning
  // S_IDLE | arbitrate and latch the winning request
  // S_REQ  | mem_req high until mem_gnt
  // S_WAIT | granted, waiting for mem_rvalid
  // S_RESP | owner's valid pulse; no arbitration this cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  state_t            r_state;
  logic              r_owner_d;
  logic [3:0]        r_starve_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_d_valid;

  logic w_d_pend;
  logic w_starved;
  logic w_sel_d;
  logic w_sel_i;
  logic w_rsp;

  assign w_d_pend  = d_read | d_write;
  assign w_starved = if_req && (r_starve_cnt == LP_STARVE_MAX);
  assign w_sel_d   = w_d_pend && !w_starved;
  assign w_sel_i   = !w_sel_d && if_req;
  // Completion only counts once the request has been granted.
  assign w_rsp     = ((r_state == S_REQ) && mem_gnt && mem_rvalid) ||
                     ((r_state == S_WAIT) && mem_rvalid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner_d    <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_if_valid   <= 1'b0;
      r_d_rdata    <= '0;
      r_d_valid    <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sel_d) begin
            r_owner_d   <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_write;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            if (if_req && (r_starve_cnt != LP_STARVE_MAX))
              r_starve_cnt <= r_starve_cnt + 4'd1;
            r_state     <= S_REQ;
          end else if (w_sel_i) begin
            r_owner_d    <= 1'b0;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
            r_starve_cnt <= 4'd0;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= mem_rvalid ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid)
            r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_rsp) begin
        if (r_owner_d) begin
          r_d_valid <= 1'b1;
          if (!r_mem_we)
            r_d_rdata <= mem_rdata;
        end else begin
          r_if_valid <= 1'b1;
          r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural memory, completion scoreboard, grant log.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt    = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata  = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct packed {logic is_d; logic [31:0] rdata;} exp_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} gnt_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  gnt_t gnt_log[$];
  int   gnt_cnt  = 0;
  logic [31:0] last_d;

  int   gnt_wait = 0;
  int   rv_lat   = 1;
  bit   same_cyc = 1'b0;
  bit   busy     = 1'b0;
  int   rv_cnt   = 0;
  int   req_age  = 0;
  logic [31:0] pend_rdata = '0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0040: return 32'h1234_5678;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [31:0] d);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts negedges from the cycle the request was driven until the owner's valid.
  task automatic wait_valid(input bit is_d, output int lat);
    lat = 0;
    @(negedge clk);
    while (!(is_d ? d_valid : if_valid)) begin
      lat++;
      if (lat > 40) begin
        check(is_d ? "wait_d_valid" : "wait_if_valid", 32'(lat), 32'd0);
        lat = -1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_gnt(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit chk_wdata);
    gnt_t g;
    if (gnt_log.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
      return;
    end
    g = gnt_log.pop_front();
    check({tag, "_addr"}, g.addr, addr);
    check({tag, "_we"}, 32'(g.we), 32'(we));
    if (chk_wdata) check({tag, "_wdata"}, g.wdata, wdata);
  endtask

  // Memory model: grants after gnt_wait cycles of mem_req, completes rv_lat cycles later.
  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hBAD0_BAD0;
    if (busy) begin
      if (rv_cnt <= 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_rdata;
        busy       = 1'b0;
      end else begin
        rv_cnt--;
      end
    end else if (mem_req) begin
      if (req_age >= gnt_wait) begin
        gnt_t g;
        mem_gnt = 1'b1;
        req_age = 0;
        gnt_cnt++;
        g.we = mem_we; g.addr = mem_addr; g.wdata = mem_wdata;
        gnt_log.push_back(g);
        pend_rdata = mem_we ? 32'hFFFF_FFFF : mem_val(mem_addr);
        if (same_cyc) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_rdata;
        end else begin
          busy   = 1'b1;
          rv_cnt = rv_lat;
        end
      end else begin
        req_age++;
      end
    end
  end

  // Scoreboard: every completion pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (if_valid || d_valid) begin
      if (if_valid && d_valid) check("dual_valid", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'({if_valid, d_valid}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_owner", 32'(d_valid), 32'(e.is_d));
        check("sb_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c0;
    bit seen;
    logic [31:0] t3_addr [5];

    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    last_d = '0;
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_valids", 32'({if_valid, d_valid}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_starve", 32'(dut.r_starve_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Single fetch, gnt at N+1, rvalid at N+2
    if_addr = 32'h100; if_req = 1'b1;
    push_exp(1'b0, 32'h0050_0093);
    wait_valid(1'b0, lat);
    check("t1_latency", 32'(lat), 32'd3);
    tick(); if_req = 1'b0;
    check_gnt("t1", 1'b0, 32'h100, 32'h0, 1'b0);

    // Same-cycle gnt and rvalid
    same_cyc = 1'b1;
    d_addr = 32'h40; d_read = 1'b1;
    push_exp(1'b1, 32'h1234_5678); last_d = 32'h1234_5678;
    wait_valid(1'b1, lat);
    check("t4_latency", 32'(lat), 32'd2);
    tick(); d_read = 1'b0; same_cyc = 1'b0;
    check_gnt("t4", 1'b0, 32'h40, 32'h0, 1'b0);

    // Data write wins over simultaneous fetch; d_rdata holds on write completion
    if_addr = 32'h104; if_req = 1'b1;
    d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_write = 1'b1;
    push_exp(1'b1, last_d);
    push_exp(1'b0, mem_val(32'h104));
    wait_valid(1'b1, lat);
    tick(); d_write = 1'b0;
    wait_valid(1'b0, lat);
    tick(); if_req = 1'b0;
    check_gnt("t2_w", 1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b1);
    check_gnt("t2_i", 1'b0, 32'h104, 32'h0, 1'b0);
    check("t2_starve", 32'(dut.r_starve_cnt), 32'd0);

    // Read and write together count as a write
    d_addr = 32'h2004; d_wdata = 32'hCAFE_F00D; d_read = 1'b1; d_write = 1'b1;
    push_exp(1'b1, last_d);
    wait_valid(1'b1, lat);
    tick(); d_read = 1'b0; d_write = 1'b0;
    check_gnt("t2b", 1'b1, 32'h2004, 32'hCAFE_F00D, 1'b1);

    // Starvation guard: four data grants, then the fetch
    gnt_wait = 1; rv_lat = 2;
    if_addr = 32'h200; if_req = 1'b1;
    d_addr = 32'h300; d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t3_addr[k] = 32'h300 + 32'(4 * k);
      push_exp(1'b1, mem_val(t3_addr[k]));
    end
    t3_addr[4] = 32'h200;
    last_d = mem_val(32'h30C);
    push_exp(1'b0, mem_val(32'h200));
    for (int k = 0; k < 4; k++) begin
      wait_valid(1'b1, lat);
      if (k == 3) check("t3_starve_sat", 32'(dut.r_starve_cnt), 32'(SMAX));
      tick(); d_addr = 32'h300 + 32'(4 * (k + 1));
    end
    wait_valid(1'b0, lat);
    check("t3_starve_clr", 32'(dut.r_starve_cnt), 32'd0);
    tick(); if_req = 1'b0; d_read = 1'b0;
    for (int k = 0; k < 5; k++)
      check_gnt("t3", 1'b0, t3_addr[k], 32'h0, 1'b0);
    gnt_wait = 0;

    // Reset while in WAIT; stale rvalid must be ignored
    rv_lat = 3;
    if_addr = 32'h500; if_req = 1'b1;
    tick(); tick();
    rst = 1'b1; if_req = 1'b0;
    tick();
    rst = 1'b0;
    last_d = '0;
    check("t5_mem_req", 32'(mem_req), 32'd0);
    check("t5_mem_addr", mem_addr, 32'd0);
    check("t5_rdata", {if_rdata[15:0], d_rdata[15:0]}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if_valid || d_valid) seen = 1'b1;
    end
    check("t5_no_valid", 32'(seen), 32'd0);
    check("t5_state_idle", 32'(dut.r_state), 32'd0);
    check_gnt("t5_abort", 1'b0, 32'h500, 32'h0, 1'b0);
    rv_lat = 1;
    tick();
    if_addr = 32'h104; if_req = 1'b1;
    push_exp(1'b0, mem_val(32'h104));
    wait_valid(1'b0, lat);
    check("t5_after_latency", 32'(lat), 32'd3);
    tick(); if_req = 1'b0;
    check_gnt("t5_after", 1'b0, 32'h104, 32'h0, 1'b0);

    // Request held through RESP, dropped the cycle after: one transaction only
    c0 = gnt_cnt;
    if_addr = 32'h600; if_req = 1'b1;
    push_exp(1'b0, mem_val(32'h600));
    wait_valid(1'b0, lat);
    tick(); if_req = 1'b0;
    repeat (5) tick();
    check("t6_gnt_count", 32'(gnt_cnt - c0), 32'd1);
    check_gnt("t6", 1'b0, 32'h600, 32'h0, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("gnt_log_drained", 32'(gnt_log.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the CPU's instruction-fetch port and its data-access port.
- Sits between the pipelined CPU's instr_*/data_* interface and the unified memory model.
- Serializes requests with one outstanding transaction at a time.
- Returns read data or write acknowledgement to the originating requester.
- Data accesses have priority; a starvation guard keeps instruction fetch moving.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before an instruction grant is forced. Legal range 1..15.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  instruction read request; level, held until if_valid
- if_addr  input  ADDR_W  fetch address
- if_rdata  output  DATA_W  fetched instruction; valid when if_valid=1
- if_valid  output  1  one-cycle completion pulse for fetch
- d_read  input  1  data read request; level, held until d_valid
- d_write  input  1  data write request; level, held until d_valid
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  write data
- d_rdata  output  DATA_W  read data; valid when d_valid=1 for a read
- d_valid  output  1  one-cycle completion pulse for a data read or write
- mem_req  output  1  memory request, held until mem_gnt
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  ADDR_W  latched request address
- mem_wdata  output  DATA_W  latched write data
- mem_gnt  input  1  memory accepts the request this cycle
- mem_rvalid  input  1  completion from memory (read data or write ack)
- mem_rdata  input  DATA_W  read data, sampled when mem_rvalid=1

Behaviour:
- Synchronous, active-high reset. Reset values:
  - state = IDLE.
  - mem_req, mem_we, if_valid and d_valid = 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata = 0.
  - Starvation counter = 0.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Data request pending = d_read | d_write.
  - Select data if a data request is pending and NOT (if_req and starve_cnt == STARVE_MAX). Otherwise select instruction if if_req=1. Otherwise stay in IDLE.
  - On selection, latch owner, address, we and wdata; go to REQ.
  - d_read and d_write both high: treated as a write.
- REQ:
  - mem_req=1 with the latched attributes.
  - mem_gnt=0: stay in REQ.
  - mem_gnt=1 and mem_rvalid=0: go to WAIT.
  - mem_gnt=1 and mem_rvalid=1 in the same cycle: capture mem_rdata and go directly to RESP.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, capture mem_rdata into the owner's rdata register; go to RESP.
- RESP:
  - Owner's valid pulses for exactly this cycle; no arbitration in this cycle.
  - Next state is IDLE. This prevents re-serving a request the requester drops after its valid pulse.
- Requester inputs that change after the latch (REQ/WAIT) are ignored.
- Write completion: d_valid pulses; d_rdata holds its previous value.
- if_rdata and d_rdata hold their last value between completions.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each data selection made while if_req=1.
  - Clears to 0 on each instruction selection.
  - Unchanged on a data selection made while if_req=0.
- mem_rvalid seen in IDLE or REQ without mem_gnt: ignored (covers a stale response after reset).
- Minimum latency, request at IDLE cycle N with gnt in N+1 and rvalid in N+2: valid asserts in cycle N+3. With gnt and rvalid both in N+1: valid in N+2.
- Reset mid-transaction: abort immediately to IDLE. No valid pulse is issued for the aborted request.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; memory gives gnt at cycle 1 and rvalid at cycle 2 with rdata=0x00500093 -> mem_addr=0x100, mem_we=0 in cycle 1; if_valid=1 and if_rdata=0x00500093 in cycle 3 only; d_valid stays 0.
- Data write priority: if_req and d_write (addr 0x2000, wdata 0xDEADBEEF) asserted together -> first mem_req has mem_we=1, addr 0x2000, wdata 0xDEADBEEF; d_valid pulses; fetch is granted next; if_valid follows.
- Starvation guard, STARVE_MAX=4: if_req held, d_read re-asserted continuously -> exactly 4 data transactions, then the 5th grant goes to instruction; the counter then returns to 0.
- Same-cycle gnt+rvalid: d_read addr 0x40 with mem_gnt and mem_rvalid both high in the REQ cycle, rdata 0x12345678 -> d_valid and d_rdata=0x12345678 on the next cycle; no WAIT state visited.
- Reset in WAIT: rst=1 for one cycle during WAIT, then a stale mem_rvalid arrives -> mem_req=0; no if_valid or d_valid pulse; state is IDLE; the next if_req is served normally.
- Held request after completion: requester keeps if_req high through the RESP cycle and drops it one cycle later -> only one memory transaction is issued.
